// File: rtl/mult_pkg.sv
// Shared constants and types for the sequential Booth multiplier.
package mult_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CAPTURE, MUL, DONE} state_t;

    typedef logic signed [DATA_W-1:0] operand_t;
    typedef logic signed [RES_W-1:0]  result_t;
    // High accumulator half carries one guard bit so -(-2^(DATA_W-1)) fits.
    typedef logic signed [DATA_W:0]   acc_hi_t;

endpackage

// File: rtl/mult_parity_chk.sv
// Combinational even-parity check over both captured operands.
module mult_parity_chk
    import mult_pkg::*;
(
    input  logic [DATA_W-1:0] arg_a,
    input  logic              arg_a_parity,
    input  logic [DATA_W-1:0] arg_b,
    input  logic              arg_b_parity,
    output logic              perr
);

    assign perr = (arg_a_parity != ^arg_a) | (arg_b_parity != ^arg_b);

endmodule

// File: rtl/mult_seq_core.sv
// Sequential signed DATA_W x DATA_W radix-2 Booth multiplier with req/ack handshake.
// Build option: define MULT_PARITY_CHECK_EN to enable operand parity checking.
module mult_seq_core
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DATA_W-1:0] arg_a,
    input  logic              arg_a_parity,
    input  logic [DATA_W-1:0] arg_b,
    input  logic              arg_b_parity,
    output logic              ack,
    output logic [RES_W-1:0]  result,
    output logic              result_parity,
    output logic              arg_parity_error,
    output logic              result_rdy
);

    state_t             state, state_nxt;
    operand_t           a_q;
    logic [DATA_W-1:0]  b_q;
    logic               pa_q, pb_q;
    acc_hi_t            hi;
    logic [DATA_W-1:0]  lo;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;
    logic               perr;
    logic               ack_nxt, rdy_nxt;

    acc_hi_t            a_ext, sum;
    acc_hi_t            hi_nxt;
    logic [DATA_W-1:0]  lo_nxt;
    result_t            prod;

`ifdef MULT_PARITY_CHECK_EN
    mult_parity_chk u_parity_chk (
        .arg_a        (a_q),
        .arg_a_parity (pa_q),
        .arg_b        (b_q),
        .arg_b_parity (pb_q),
        .perr         (perr)
    );
`else
    logic unused_parity;
    assign unused_parity = pa_q ^ pb_q;
    assign perr          = 1'b0;
`endif

    // One Booth step on {lo[0], q_m1} followed by an arithmetic right shift.
    always_comb begin
        a_ext = acc_hi_t'(a_q);
        case ({lo[0], q_m1})
            2'b01:   sum = hi + a_ext;
            2'b10:   sum = hi - a_ext;
            default: sum = hi;
        endcase
        hi_nxt = {sum[DATA_W], sum[DATA_W:1]};
        lo_nxt = {sum[0], lo[DATA_W-1:1]};
        prod   = result_t'({hi[DATA_W-1:0], lo});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        rdy_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = CAPTURE;
                    ack_nxt   = 1'b1;
                end
            end
            CAPTURE: state_nxt = perr ? DONE : MUL;
            MUL:     if (cnt == '0) state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                rdy_nxt   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q              <= '0;
            b_q              <= '0;
            pa_q             <= 1'b0;
            pb_q             <= 1'b0;
            hi               <= '0;
            lo               <= '0;
            q_m1             <= 1'b0;
            cnt              <= '0;
            err_q            <= 1'b0;
            ack              <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
            result_rdy       <= 1'b0;
        end else begin
            ack        <= ack_nxt;
            result_rdy <= rdy_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        a_q  <= operand_t'(arg_a);
                        b_q  <= arg_b;
                        pa_q <= arg_a_parity;
                        pb_q <= arg_b_parity;
                    end
                end
                CAPTURE: begin
                    // A parity failure leaves a zero accumulator so DONE emits 0.
                    hi    <= '0;
                    lo    <= perr ? '0 : b_q;
                    q_m1  <= 1'b0;
                    cnt   <= CNT_W'(DATA_W - 1);
                    err_q <= perr;
                end
                MUL: begin
                    hi   <= hi_nxt;
                    lo   <= lo_nxt;
                    q_m1 <= lo[0];
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    result           <= prod;
                    result_parity    <= ^prod;
                    arg_parity_error <= err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_core.sv
// Directed and req-held-high self-checking bench for mult_seq_core.
module tb_mult_seq_core;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [15:0] arg_a;
    logic        arg_a_parity;
    logic [15:0] arg_b;
    logic        arg_b_parity;
    logic        ack;
    logic [31:0] result;
    logic        result_parity;
    logic        arg_parity_error;
    logic        result_rdy;

    int n_cmp = 0;
    int n_err = 0;

    mult_seq_core dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .arg_a            (arg_a),
        .arg_a_parity     (arg_a_parity),
        .arg_b            (arg_b),
        .arg_b_parity     (arg_b_parity),
        .ack              (ack),
        .result           (result),
        .result_parity    (result_parity),
        .arg_parity_error (arg_parity_error),
        .result_rdy       (result_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single req pulse; lat counts edges from the sampling edge to result_rdy (-1 on timeout).
    task automatic do_op(input logic [15:0] a, input logic pa, input logic [15:0] b, input logic pb,
                         output logic [31:0] res, output logic rp, output logic err,
                         output int lat, output logic ack_seen);
        logic done;
        @(negedge clk);
        arg_a = a; arg_a_parity = pa; arg_b = b; arg_b_parity = pb; req = 1'b1;
        @(posedge clk);
        lat = 0; ack_seen = 1'b0; done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            req = 1'b0;
            if (n == 0) ack_seen = ack;
            if (result_rdy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!done) lat = -1;
        res = result; rp = result_parity; err = arg_parity_error;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0;
        arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ack, result, result_parity, arg_parity_error, result_rdy} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b res=%h rp=%b err=%b rdy=%b, want all 0",
                     ack, result, result_parity, arg_parity_error, result_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_corners();
        logic [15:0] va [5] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
        logic [15:0] vb [5] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h7FFF};
        logic [31:0] vr [5] = '{32'h40000000, 32'hC0008000, 32'h00000000, 32'h00000001, 32'h3FFF0001};
        logic        vp [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] res; logic rp, err, ak; int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], ^va[i], vb[i], ^vb[i], res, rp, err, lat, ak);
            n_cmp++;
            if (res !== vr[i]) begin
                n_err++; $display("FAIL corner%0d_result: got %h want %h", i, res, vr[i]);
            end
            n_cmp++;
            if ({rp, err} !== {vp[i], 1'b0}) begin
                n_err++; $display("FAIL corner%0d_parity_err: got rp=%b err=%b want rp=%b err=0", i, rp, err, vp[i]);
            end
            n_cmp++;
            if (lat !== 18) begin
                n_err++; $display("FAIL corner%0d_latency: got %0d want 18", i, lat);
            end
            n_cmp++;
            if (ak !== 1'b1) begin
                n_err++; $display("FAIL corner%0d_ack: got %b want 1", i, ak);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int rdy_cnt = 0;
        logic [31:0] res; logic rp, err, ak; int lat;
        @(negedge clk);
        arg_a = 16'h0002; arg_a_parity = 1'b1; arg_b = 16'h0003; arg_b_parity = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ack, result, result_parity, arg_parity_error, result_rdy} !== 36'h0) begin
            n_err++;
            $display("FAIL midmul_reset_outputs: got ack=%b res=%h rp=%b err=%b rdy=%b, want all 0",
                     ack, result, result_parity, arg_parity_error, result_rdy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (result_rdy) rdy_cnt++;
        end
        n_cmp++;
        if (rdy_cnt !== 0) begin
            n_err++; $display("FAIL midmul_no_rdy: got %0d strobes want 0", rdy_cnt);
        end
        do_op(16'h0005, 1'b0, 16'hFFFD, 1'b1, res, rp, err, lat, ak);
        n_cmp++;
        if ({res, rp, err} !== {32'hFFFFFFF1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL midmul_after_reset: got res=%h rp=%b err=%b want FFFFFFF1 1 0", res, rp, err);
        end
        n_cmp++;
        if (lat !== 18) begin
            n_err++; $display("FAIL midmul_after_latency: got %0d want 18", lat);
        end
    endtask

    task automatic test_parity_error();
        logic [31:0] res; logic rp, err, ak; int lat;
        logic [31:0] e_res [2];
        logic        e_rp  [2];
        logic        e_err [2];
        int          e_lat [2];
        logic [31:0] got_res [2];
        logic        got_rp [2], got_err [2];
        int          got_lat [2];
`ifdef MULT_PARITY_CHECK_EN
        e_res = '{32'h0, 32'h0}; e_rp = '{1'b0, 1'b0}; e_err = '{1'b1, 1'b1}; e_lat = '{2, 2};
`else
        e_res = '{32'h3FFF0001, 32'h00000003}; e_rp = '{1'b1, 1'b0}; e_err = '{1'b0, 1'b0}; e_lat = '{18, 18};
`endif
        do_op(16'h7FFF, 1'b0, 16'h7FFF, 1'b1, res, rp, err, lat, ak);
        got_res[0] = res; got_rp[0] = rp; got_err[0] = err; got_lat[0] = lat;
        do_op(16'h0003, 1'b0, 16'h0001, 1'b0, res, rp, err, lat, ak);
        got_res[1] = res; got_rp[1] = rp; got_err[1] = err; got_lat[1] = lat;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({got_res[i], got_rp[i], got_err[i]} !== {e_res[i], e_rp[i], e_err[i]}) begin
                n_err++;
                $display("FAIL perr%0d_outputs: got res=%h rp=%b err=%b want res=%h rp=%b err=%b",
                         i, got_res[i], got_rp[i], got_err[i], e_res[i], e_rp[i], e_err[i]);
            end
            n_cmp++;
            if (got_lat[i] !== e_lat[i]) begin
                n_err++; $display("FAIL perr%0d_latency: got %0d want %0d", i, got_lat[i], e_lat[i]);
            end
        end
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h7FFF;
            4: return 16'h8000;
            5: return 16'h8001;
            6: return 16'h7FFE;
            default: return 16'($urandom);
        endcase
    endfunction

    // req held high; operands for the next op are driven right after ack to expose any live-input use.
    task automatic test_back_to_back();
        logic [15:0] cur_a, cur_b;
        logic [31:0] exp;
        int w, c, extra;
        cur_a = pick_operand(); cur_b = pick_operand();
        @(negedge clk);
        arg_a = cur_a; arg_a_parity = ^cur_a; arg_b = cur_b; arg_b_parity = ^cur_b; req = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!ack && w < 40);
            n_cmp++;
            if (w !== 1) begin
                n_err++; $display("FAIL b2b%0d_ack_gap: got %0d cycles want 1", i, w);
                if (!ack) break;
            end
            exp = 32'(int'($signed(cur_a)) * int'($signed(cur_b)));
            cur_a = pick_operand(); cur_b = pick_operand();
            arg_a = cur_a; arg_a_parity = ^cur_a; arg_b = cur_b; arg_b_parity = ^cur_b;
            c = 0; extra = 0;
            do begin
                @(negedge clk); c++;
                if (ack) extra++;
            end while (!result_rdy && c < 40);
            if (i == 999) req = 1'b0;
            n_cmp++;
            if (c !== 18) begin
                n_err++; $display("FAIL b2b%0d_latency: got %0d want 18", i, c);
            end
            n_cmp++;
            if (extra !== 0) begin
                n_err++; $display("FAIL b2b%0d_extra_ack: got %0d want 0", i, extra);
            end
            n_cmp++;
            if ({result, result_parity, arg_parity_error} !== {exp, ^exp, 1'b0}) begin
                n_err++;
                $display("FAIL b2b%0d_result: got res=%h rp=%b err=%b want res=%h rp=%b err=0",
                         i, result, result_parity, arg_parity_error, exp, ^exp);
            end
        end
        req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_corners();
        test_reset_mid_mul();
        test_parity_error();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
